base_table_ctrl: RTL and testbench

- Sequences and arbitrates one single-port, bit-masked base-prediction table SRAM: 256 entries x 9 bits, one access per cycle, read or write.
- Shares the port between three users:
  - a predictor lookup stream (reads, one-cycle response);
  - a training update stream (masked writes through a one-entry buffer);
  - an internal init sweep that writes every entry after reset or flush.
- Sits between the predictor front-end and the table SRAM wrapper.

---
 rtl/base_table_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_base_table_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/base_table_ctrl.sv
// Port sequencer for the single-port, bit-masked base-prediction table SRAM.
// Optional lookup bypass of the buffered update: BASE_TABLE_CTRL_BYPASS_EN.
module base_table_ctrl #(
    parameter int unsigned       ADDR_W     = 8,
    parameter int unsigned       DEPTH      = 2 ** ADDR_W,
    parameter int unsigned       DATA_W     = 9,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    parameter int unsigned       MAX_STALL  = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              flush,
    output logic              init_busy,
    input  logic              lk_valid,
    output logic              lk_ready,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_resp_valid,
    output logic [DATA_W-1:0] lk_resp_data,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [ADDR_W-1:0] up_addr,
    input  logic [DATA_W-1:0] up_wdata,
    input  logic [DATA_W-1:0] up_wmask,
    output logic              ram_en,
    output logic              ram_wmode,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_wmask,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam int unsigned        STALL_W   = $clog2(MAX_STALL + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(MAX_STALL);
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]         state_q,     state_d;
    logic [ADDR_W-1:0]  init_cnt_q,  init_cnt_d;
    logic               buf_vld_q,   buf_vld_d;
    logic [ADDR_W-1:0]  buf_addr_q,  buf_addr_d;
    logic [DATA_W-1:0]  buf_wdata_q, buf_wdata_d;
    logic [DATA_W-1:0]  buf_wmask_q, buf_wmask_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               resp_vld_q,  resp_vld_d;

    logic run;
    logic in_init;
    logic forced;
    logic lk_acc;
    logic drain;
    logic up_acc;

    assign run     = (state_q == ST_RUN);
    assign in_init = ~run;

    // A starved update blocks lookups once it has lost MAX_STALL times.
    assign forced   = buf_vld_q && (stall_cnt_q == STALL_MAX);
    assign lk_ready = run && !forced;
    assign lk_acc   = lk_valid && lk_ready;

    // A flushed buffer is discarded, so it must never reach the SRAM.
    assign drain    = run && buf_vld_q && !flush && !lk_acc;
    assign up_ready = run && !flush && (!buf_vld_q || drain);
    assign up_acc   = up_valid && up_ready;

    assign init_busy     = in_init;
    assign lk_resp_valid = resp_vld_q;

    always_comb begin
        ram_en    = 1'b0;
        ram_wmode = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wmask = '0;
        unique case (1'b1)
            in_init: begin
                ram_en    = 1'b1;
                ram_wmode = 1'b1;
                ram_addr  = init_cnt_q;
                ram_wdata = INIT_VALUE;
                ram_wmask = '1;
            end
            lk_acc: begin
                ram_en    = 1'b1;
                ram_wmode = 1'b0;
                ram_addr  = lk_addr;
            end
            drain: begin
                ram_en    = 1'b1;
                ram_wmode = 1'b1;
                ram_addr  = buf_addr_q;
                ram_wdata = buf_wdata_q;
                ram_wmask = buf_wmask_q;
            end
            default: begin
                ram_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (flush) begin
            state_d    = ST_INIT;
            init_cnt_d = '0;
        end else if (in_init) begin
            init_cnt_d = init_cnt_q + ADDR_W'(1);
            if (init_cnt_q == LAST_ADDR) begin
                state_d = ST_RUN;
            end
        end
    end

    always_comb begin
        buf_vld_d   = buf_vld_q;
        buf_addr_d  = buf_addr_q;
        buf_wdata_d = buf_wdata_q;
        buf_wmask_d = buf_wmask_q;
        if (run && flush) begin
            buf_vld_d = 1'b0;
        end else if (up_acc) begin
            buf_vld_d   = 1'b1;
            buf_addr_d  = up_addr;
            buf_wdata_d = up_wdata;
            buf_wmask_d = up_wmask;
        end else if (drain) begin
            buf_vld_d = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (in_init || flush || drain) begin
            stall_cnt_d = '0;
        end else if (buf_vld_q && lk_acc && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + STALL_W'(1);
        end
    end

    assign resp_vld_d = lk_acc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            buf_vld_q   <= 1'b0;
            buf_addr_q  <= '0;
            buf_wdata_q <= '0;
            buf_wmask_q <= '0;
            stall_cnt_q <= '0;
            resp_vld_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            buf_vld_q   <= buf_vld_d;
            buf_addr_q  <= buf_addr_d;
            buf_wdata_q <= buf_wdata_d;
            buf_wmask_q <= buf_wmask_d;
            stall_cnt_q <= stall_cnt_d;
            resp_vld_q  <= resp_vld_d;
        end
    end

`ifdef BASE_TABLE_CTRL_BYPASS_EN
    logic              byp_hit;
    logic              byp_vld_q,   byp_vld_d;
    logic [DATA_W-1:0] byp_wdata_q, byp_wdata_d;
    logic [DATA_W-1:0] byp_wmask_q, byp_wmask_d;

    // The lookup read the pre-update entry; merge the buffered bits on return.
    assign byp_hit = lk_acc && buf_vld_q && !flush && (buf_addr_q == lk_addr);

    always_comb begin
        byp_vld_d   = byp_hit;
        byp_wdata_d = byp_wdata_q;
        byp_wmask_d = byp_wmask_q;
        if (byp_hit) begin
            byp_wdata_d = buf_wdata_q;
            byp_wmask_d = buf_wmask_q;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            byp_vld_q   <= 1'b0;
            byp_wdata_q <= '0;
            byp_wmask_q <= '0;
        end else begin
            byp_vld_q   <= byp_vld_d;
            byp_wdata_q <= byp_wdata_d;
            byp_wmask_q <= byp_wmask_d;
        end
    end

    assign lk_resp_data = byp_vld_q
        ? ((ram_rdata & ~byp_wmask_q) | (byp_wdata_q & byp_wmask_q))
        : ram_rdata;
`else
    assign lk_resp_data = ram_rdata;
`endif

endmodule

// File: tb/tb_base_table_ctrl.sv
// Self-checking bench for base_table_ctrl: directed vector table, init/flush
// sweeps and a randomized run against a table-level reference model.
module tb_base_table_ctrl;

    localparam int AW    = 8;
    localparam int DW    = 9;
    localparam int DEPTH = 256;
    localparam int MAXS  = 4;

`ifdef BASE_TABLE_CTRL_BYPASS_EN
    localparam logic [DW-1:0] BYP_EXP = 9'h0F0;
`else
    localparam logic [DW-1:0] BYP_EXP = 9'h000;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          flush = 1'b0;
    logic          init_busy;
    logic          lk_valid = 1'b0;
    logic          lk_ready;
    logic [AW-1:0] lk_addr = '0;
    logic          lk_resp_valid;
    logic [DW-1:0] lk_resp_data;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [AW-1:0] up_addr = '0;
    logic [DW-1:0] up_wdata = '0;
    logic [DW-1:0] up_wmask = '0;
    logic          ram_en;
    logic          ram_wmode;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_wmask;
    logic [DW-1:0] ram_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    base_table_ctrl dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .init_busy(init_busy),
        .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_addr(lk_addr),
        .lk_resp_valid(lk_resp_valid), .lk_resp_data(lk_resp_data),
        .up_valid(up_valid), .up_ready(up_ready), .up_addr(up_addr),
        .up_wdata(up_wdata), .up_wmask(up_wmask),
        .ram_en(ram_en), .ram_wmode(ram_wmode), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_wmask(ram_wmask),
        .ram_rdata(ram_rdata)
    );

    // Behavioural single-port SRAM with bit mask and one-cycle read.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q = '0;
    always @(posedge clock) begin
        if (ram_en) begin
            if (ram_wmode)
                mem[ram_addr] <= (mem[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            else
                rd_q <= mem[ram_addr];
        end
    end
    assign ram_rdata = rd_q;

    function automatic logic [DW-1:0] mrg(input logic [DW-1:0] old,
                                          input logic [DW-1:0] d,
                                          input logic [DW-1:0] m);
        return (old & ~m) | (d & m);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic drive(input logic lv, input logic [AW-1:0] la,
                         input logic uv, input logic [AW-1:0] ua,
                         input logic [DW-1:0] ud, input logic [DW-1:0] um,
                         input logic fl);
        lk_valid = lv;
        lk_addr  = la;
        up_valid = uv;
        up_addr  = ua;
        up_wdata = ud;
        up_wmask = um;
        flush    = fl;
    endtask

    // Starts at a negedge with the sweep at address 0; ends at a negedge.
    task automatic sweep(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk({tag, "_busy"}, init_busy, 1);
            chk({tag, "_wr"}, {ram_en, ram_wmode}, 2'b11);
            chk({tag, "_addr"}, ram_addr, i);
            chk({tag, "_data"}, {ram_wdata, ram_wmask}, {9'h000, 9'h1FF});
            chk({tag, "_rdy"}, {lk_ready, up_ready}, 2'b00);
            @(negedge clock);
        end
        #1;
        chk({tag, "_done_busy"}, init_busy, 0);
        chk({tag, "_done_rdy"}, {lk_ready, up_ready}, 2'b11);
        @(negedge clock);
    endtask

    typedef struct {
        logic          lv;
        logic [AW-1:0] la;
        logic          uv;
        logic [AW-1:0] ua;
        logic [DW-1:0] ud;
        logic [DW-1:0] um;
        logic          e_lrdy;
        logic          e_urdy;
        logic          e_en;
        logic          e_wm;
        logic [AW-1:0] e_addr;
        logic          e_rv;
        logic [DW-1:0] e_rd;
    } vec_t;

    function automatic vec_t mk(input logic lv, input logic [AW-1:0] la,
                                input logic uv, input logic [AW-1:0] ua,
                                input logic [DW-1:0] ud, input logic [DW-1:0] um,
                                input logic lr, input logic ur,
                                input logic en, input logic wm,
                                input logic [AW-1:0] ad,
                                input logic rv, input logic [DW-1:0] rd);
        vec_t v;
        v.lv = lv; v.la = la; v.uv = uv; v.ua = ua; v.ud = ud; v.um = um;
        v.e_lrdy = lr; v.e_urdy = ur; v.e_en = en; v.e_wm = wm;
        v.e_addr = ad; v.e_rv = rv; v.e_rd = rd;
        return v;
    endfunction

    vec_t vt [17];

    // Reference model state for the randomized phase.
    logic [DW-1:0] ref_tbl [DEPTH];
    logic          pv;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    logic [DW-1:0] pm;
    int            stall;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0]  = mk(0, 8'h00, 1, 8'h12, 9'h1A5, 9'h1FF, 1, 1, 0, 0, 8'h00, 0, 9'h000);
        vt[1]  = mk(0, 8'h00, 0, 8'h00, 9'h000, 9'h000, 1, 1, 1, 1, 8'h12, 0, 9'h000);
        vt[2]  = mk(1, 8'h12, 0, 8'h00, 9'h000, 9'h000, 1, 1, 1, 0, 8'h12, 1, 9'h1A5);
        vt[3]  = mk(1, 8'h12, 1, 8'h40, 9'h0AB, 9'h1FF, 1, 1, 1, 0, 8'h12, 1, 9'h1A5);
        vt[4]  = mk(1, 8'h01, 0, 8'h00, 9'h000, 9'h000, 1, 0, 1, 0, 8'h01, 1, 9'h000);
        vt[5]  = mk(1, 8'h02, 0, 8'h00, 9'h000, 9'h000, 1, 0, 1, 0, 8'h02, 1, 9'h000);
        vt[6]  = mk(1, 8'h03, 0, 8'h00, 9'h000, 9'h000, 1, 0, 1, 0, 8'h03, 1, 9'h000);
        vt[7]  = mk(1, 8'h04, 0, 8'h00, 9'h000, 9'h000, 1, 0, 1, 0, 8'h04, 1, 9'h000);
        vt[8]  = mk(1, 8'h40, 0, 8'h00, 9'h000, 9'h000, 0, 1, 1, 1, 8'h40, 0, 9'h000);
        vt[9]  = mk(1, 8'h40, 0, 8'h00, 9'h000, 9'h000, 1, 1, 1, 0, 8'h40, 1, 9'h0AB);
        vt[10] = mk(0, 8'h00, 1, 8'h05, 9'h1FF, 9'h00F, 1, 1, 0, 0, 8'h00, 0, 9'h000);
        vt[11] = mk(0, 8'h00, 0, 8'h00, 9'h000, 9'h000, 1, 1, 1, 1, 8'h05, 0, 9'h000);
        vt[12] = mk(1, 8'h05, 0, 8'h00, 9'h000, 9'h000, 1, 1, 1, 0, 8'h05, 1, 9'h00F);
        vt[13] = mk(0, 8'h00, 1, 8'h30, 9'h0F0, 9'h0F0, 1, 1, 0, 0, 8'h00, 0, 9'h000);
        vt[14] = mk(1, 8'h30, 0, 8'h00, 9'h000, 9'h000, 1, 0, 1, 0, 8'h30, 1, BYP_EXP);
        vt[15] = mk(0, 8'h00, 0, 8'h00, 9'h000, 9'h000, 1, 1, 1, 1, 8'h30, 0, 9'h000);
        vt[16] = mk(1, 8'h30, 0, 8'h00, 9'h000, 9'h000, 1, 1, 1, 0, 8'h30, 1, 9'h0F0);

        // Reset
        @(negedge clock);
        @(negedge clock);
        chk("rst_busy", init_busy, 1);
        chk("rst_rdy", {lk_ready, up_ready}, 2'b00);
        chk("rst_resp", lk_resp_valid, 0);
        reset_n = 1'b1;
        sweep("init");

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            drive(vt[i].lv, vt[i].la, vt[i].uv, vt[i].ua, vt[i].ud, vt[i].um, 0);
            #1;
            chk($sformatf("v%0d_lk_ready", i), lk_ready, vt[i].e_lrdy);
            chk($sformatf("v%0d_up_ready", i), up_ready, vt[i].e_urdy);
            chk($sformatf("v%0d_ram_en", i), ram_en, vt[i].e_en);
            if (vt[i].e_en) begin
                chk($sformatf("v%0d_wmode", i), ram_wmode, vt[i].e_wm);
                chk($sformatf("v%0d_addr", i), ram_addr, vt[i].e_addr);
            end
            @(negedge clock);
            chk($sformatf("v%0d_resp_valid", i), lk_resp_valid, vt[i].e_rv);
            if (vt[i].e_rv)
                chk($sformatf("v%0d_resp_data", i), lk_resp_data, vt[i].e_rd);
        end

        // Flush with an update buffered and a lookup accepted in the flush cycle
        drive(1, 8'h10, 1, 8'h77, 9'h1FF, 9'h1FF, 0);
        #1;
        chk("fl_a_up_ready", up_ready, 1);
        chk("fl_a_ram", {ram_en, ram_wmode, ram_addr}, {2'b10, 8'h10});
        @(negedge clock);
        chk("fl_a_resp", {lk_resp_valid, lk_resp_data}, {1'b1, 9'h000});
        drive(1, 8'h12, 0, 8'h00, 9'h000, 9'h000, 1);
        #1;
        chk("fl_b_lk_ready", lk_ready, 1);
        chk("fl_b_ram", {ram_en, ram_wmode, ram_addr}, {2'b10, 8'h12});
        @(negedge clock);
        chk("fl_b_resp", {lk_resp_valid, lk_resp_data}, {1'b1, 9'h1A5});
        drive(0, 8'h00, 0, 8'h00, 9'h000, 9'h000, 0);
        sweep("flush");
        drive(1, 8'h77, 0, 8'h00, 9'h000, 9'h000, 0);
        @(negedge clock);
        chk("fl_77_resp", {lk_resp_valid, lk_resp_data}, {1'b1, 9'h000});
        drive(1, 8'h12, 0, 8'h00, 9'h000, 9'h000, 0);
        @(negedge clock);
        chk("fl_12_resp", {lk_resp_valid, lk_resp_data}, {1'b1, 9'h000});
        drive(0, 8'h00, 0, 8'h00, 9'h000, 9'h000, 0);
        @(negedge clock);

        // Randomized traffic against the table-level model
        for (int i = 0; i < DEPTH; i++) ref_tbl[i] = 9'h000;
        pv = 1'b0; pa = '0; pd = '0; pm = '0; stall = 0;
        for (int n = 0; n < 3000; n++) begin
            logic          lv, uv, forced, win, drn, e_ur;
            logic [AW-1:0] la, ua;
            logic [DW-1:0] exp_rd;
            lv = ($urandom_range(0, 9) < 6);
            uv = ($urandom_range(0, 9) < 5);
            la = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            ua = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
            drive(lv, la, uv, ua, DW'($urandom), DW'($urandom), 0);
            #1;
            forced = pv && (stall == MAXS);
            win    = lv && !forced;
            drn    = pv && !win;
            e_ur   = !pv || drn;
            exp_rd = '0;
            chk("rnd_lk_ready", lk_ready, !forced);
            chk("rnd_up_ready", up_ready, e_ur);
            chk("rnd_ram_en", ram_en, win || pv);
            if (win) begin
                chk("rnd_rd", {ram_wmode, ram_addr}, {1'b0, la});
                exp_rd = ref_tbl[la];
`ifdef BASE_TABLE_CTRL_BYPASS_EN
                if (pv && pa == la) exp_rd = mrg(exp_rd, pd, pm);
`endif
            end else if (pv) begin
                chk("rnd_wr", {ram_wmode, ram_addr, ram_wdata, ram_wmask},
                    {1'b1, pa, pd, pm});
            end
            if (drn) begin
                ref_tbl[pa] = mrg(ref_tbl[pa], pd, pm);
                pv = 1'b0;
                stall = 0;
            end else if (pv && win && stall < MAXS) begin
                stall++;
            end
            if (uv && e_ur) begin
                pv = 1'b1;
                pa = up_addr;
                pd = up_wdata;
                pm = up_wmask;
            end
            @(negedge clock);
            chk("rnd_resp_valid", lk_resp_valid, win);
            if (win) chk("rnd_resp_data", lk_resp_data, exp_rd);
        end
        drive(0, 8'h00, 0, 8'h00, 9'h000, 9'h000, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
